// File: rtl/pcm_tdm_serializer.sv
// Purpose : buffers PCM frames in a small FIFO and serialises them as an I2S or
//           left-justified TDM stream with a divided bit clock and LR frame sync.
// Latency : a frame accepted during frame N is transmitted in frame N+1 at the earliest.
// Backpressure: frame_ready drops while the FIFO holds FIFO_DEPTH frames.
// Ports   : clk, rst_active_high (sync, active-high); frame_data/frame_valid/frame_ready
//           (push side); mute (sampled at frame load); serial_data_out, bit_clock_out,
//           LR_select (DAC side); underrun (one-clk pulse); fifo_level (queued frames).
module pcm_tdm_serializer #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FORMAT     = 0
) (
  input  logic                               clk,
  input  logic                               rst_active_high,
  input  logic [CHANNELS*SAMPLE_W-1:0]       frame_data,
  input  logic                               frame_valid,
  output logic                               frame_ready,
  input  logic                               mute,
  output logic                               serial_data_out,
  output logic                               bit_clock_out,
  output logic                               LR_select,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int DW    = CHANNELS * SAMPLE_W;
  localparam int FRAME = CHANNELS * SLOT_W;
  localparam int HALF  = BCLK_DIV / 2;
  localparam int DCW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW    = $clog2(FRAME);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [DCW-1:0] DIV_LAST = DCW'(HALF - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0]  R_START  = CW'((CHANNELS / 2) * SLOT_W);
  localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);
  localparam bit             LJ_MODE  = (FORMAT == 1);

  logic [DCW-1:0]   div_cnt;
  logic [CW-1:0]    bit_cnt;
  logic             running;    // low until the first bit period of the silent frame 0
  logic [FRAME-1:0] sreg;       // current frame, left-justified, current period at MSB
  logic             lj_prev;    // left-justified bit of the previous period (I2S delay)
  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [LW-1:0]    level, level_next;

  logic             half_tick, fall, frame_end, load, fifo_empty, push, pop, lj_bit;
  logic [CW-1:0]    next_cnt;
  logic [DW-1:0]    load_data;
  logic [FRAME-1:0] load_vec;

  assign half_tick  = (div_cnt == DIV_LAST);
  assign fall       = half_tick && bit_clock_out;
  assign frame_end  = !running || (bit_cnt == CNT_LAST);
  assign load       = fall && frame_end;
  assign fifo_empty = (level == '0);
  // Frame 0 after reset is silent: it neither pops nor reports underrun.
  assign pop        = load && running && !fifo_empty;
  assign push       = frame_valid && frame_ready;
  assign next_cnt   = frame_end ? '0 : bit_cnt + 1'b1;
  assign load_data  = (!running || fifo_empty || mute) ? '0 : mem[rptr];
  assign lj_bit     = load ? load_vec[FRAME-1] : sreg[FRAME-2];
  assign fifo_level = level;

  // Place channel s sample MSB-first at the start of slot s, zero padding behind it.
  always_comb begin
    load_vec = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      for (int b = 0; b < SAMPLE_W; b++) begin
        load_vec[FRAME-1-s*SLOT_W-b] = load_data[s*SAMPLE_W+SAMPLE_W-1-b];
      end
    end
  end

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= frame_data;
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      div_cnt         <= '0;
      bit_clock_out   <= 1'b0;
      bit_cnt         <= '0;
      running         <= 1'b0;
      sreg            <= '0;
      lj_prev         <= 1'b0;
      serial_data_out <= 1'b0;
      LR_select       <= 1'b0;
      underrun        <= 1'b0;
      wptr            <= '0;
      rptr            <= '0;
      level           <= '0;
      frame_ready     <= 1'b0;
    end else begin
      div_cnt  <= half_tick ? '0 : div_cnt + 1'b1;
      underrun <= load && running && fifo_empty;
      if (half_tick) bit_clock_out <= ~bit_clock_out;
      if (fall) begin
        bit_cnt   <= next_cnt;
        running   <= 1'b1;
        sreg      <= load ? load_vec : (sreg << 1);
        lj_prev   <= lj_bit;
        // I2S emits the previous period's bit, so the delay carries across frame wrap.
        serial_data_out <= LJ_MODE ? lj_bit : lj_prev;
        LR_select <= (next_cnt >= R_START);
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level       <= level_next;
      frame_ready <= (level_next != LVL_FULL);
    end
  end

endmodule
